// File: rtl/phase_datapath.sv
// Four-phase datapath: fetch, register read, ALU, write-back, driven by the
// phase code from the control unit, with phase-order checking and HALT.
module phase_datapath #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        phase,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic [PC_W-1:0]   pc,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic              zero,
    output logic              carry,
    output logic              retire,
    output logic              illegal_op,
    output logic              halted,
    output logic              seq_err
);

    typedef enum logic [1:0] {
        PH_F  = 2'b00,
        PH_D  = 2'b01,
        PH_E  = 2'b10,
        PH_WB = 2'b11
    } phase_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_MOV  = 4'h7,
        OP_ADDI = 4'h8,
        OP_JMP  = 4'h9,
        OP_BZ   = 4'hA,
        OP_HALT = 4'hB
    } opcode_t;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
    } instr_t;

    instr_t                  ir;
    logic [3:0][DATA_W-1:0]  rf;
    logic [DATA_W-1:0]       op_a;
    logic [DATA_W-1:0]       op_b;
    logic [DATA_W-1:0]       result;
    logic                    br_take;
    logic [1:0]              exp_phase;

    logic [DATA_W-1:0]       imm_d;
    logic [PC_W-1:0]         imm_pc;
    logic [PC_W-1:0]         pc_inc;
    logic [PC_W-1:0]         next_pc;
    logic [DATA_W:0]         wide;
    logic [DATA_W-1:0]       alu_y;
    logic                    alu_c;
    logic                    alu_fen;
    logic                    writes_rd;
    logic                    is_illegal;

    assign imem_addr = pc;
    assign dbg_data  = rf[dbg_sel];
    assign imm_d     = DATA_W'(ir.imm);
    assign imm_pc    = PC_W'(ir.imm);
    assign pc_inc    = pc + PC_W'(1);

    // ALU: wide carries the carry/borrow out of the top bit for ADD/ADDI/SUB.
    always_comb begin
        wide    = '0;
        alu_y   = '0;
        alu_c   = 1'b0;
        alu_fen = 1'b0;
        case (ir.op)
            OP_LDI:  alu_y = imm_d;
            OP_ADD: begin
                wide    = {1'b0, op_a} + {1'b0, op_b};
                alu_y   = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
                alu_fen = 1'b1;
            end
            OP_SUB: begin
                wide    = {1'b0, op_a} - {1'b0, op_b};
                alu_y   = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
                alu_fen = 1'b1;
            end
            OP_AND: begin
                alu_y   = op_a & op_b;
                alu_fen = 1'b1;
            end
            OP_OR: begin
                alu_y   = op_a | op_b;
                alu_fen = 1'b1;
            end
            OP_XOR: begin
                alu_y   = op_a ^ op_b;
                alu_fen = 1'b1;
            end
            OP_MOV:  alu_y = op_b;
            OP_ADDI: begin
                wide    = {1'b0, op_a} + {1'b0, imm_d};
                alu_y   = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
                alu_fen = 1'b1;
            end
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        writes_rd  = (ir.op >= OP_LDI) && (ir.op <= OP_ADDI);
        is_illegal = (ir.op > OP_HALT);
        case (ir.op)
            OP_JMP:  next_pc = imm_pc;
            OP_BZ:   next_pc = br_take ? imm_pc : pc_inc;
            default: next_pc = pc_inc;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= '0;
            ir         <= '0;
            op_a       <= '0;
            op_b       <= '0;
            result     <= '0;
            rf         <= '0;
            zero       <= 1'b0;
            carry      <= 1'b0;
            br_take    <= 1'b0;
            retire     <= 1'b0;
            illegal_op <= 1'b0;
            halted     <= 1'b0;
            seq_err    <= 1'b0;
            exp_phase  <= PH_F;
        end else begin
            exp_phase  <= phase + 2'd1;
            retire     <= 1'b0;
            illegal_op <= 1'b0;
            if (phase != exp_phase)
                seq_err <= 1'b1;
            // The phase input still steers actions even after an order error.
            if (!halted) begin
                case (phase)
                    PH_F: ir <= imem_rdata;
                    PH_D: begin
                        op_a <= rf[ir.rd];
                        op_b <= rf[ir.rs];
                    end
                    PH_E: begin
                        result  <= alu_y;
                        // BZ decides on the flag as it was before this E edge.
                        br_take <= zero;
                        if (alu_fen) begin
                            zero  <= (alu_y == '0);
                            carry <= alu_c;
                        end
                    end
                    default: begin
                        if (writes_rd)
                            rf[ir.rd] <= result;
                        if (ir.op == OP_HALT)
                            halted <= 1'b1;
                        else
                            pc <= next_pc;
                        retire     <= 1'b1;
                        illegal_op <= is_illegal;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_datapath.sv
// Directed bench for phase_datapath: program sequences with hand-derived results.
module tb_phase_datapath;
    localparam int DATA_W = 8;
    localparam int PC_W   = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        phase = 2'b00;
    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_rdata;
    logic [PC_W-1:0]   pc;
    logic [1:0]        dbg_sel = 2'd0;
    logic [DATA_W-1:0] dbg_data;
    logic              zero, carry, retire, illegal_op, halted, seq_err;

    logic [15:0] imem [0:255];
    int n_cmp = 0;
    int n_err = 0;

    assign imem_rdata = imem[imem_addr];

    always #5 clock = ~clock;

    phase_datapath #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .clock(clock), .reset(reset), .phase(phase),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data),
        .zero(zero), .carry(carry), .retire(retire),
        .illegal_op(illegal_op), .halted(halted), .seq_err(seq_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [1:0] ph);
        phase = ph;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        phase = 2'b00;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_reg(input int idx, input logic [7:0] exp);
        dbg_sel = 2'(idx);
        #1;
        chk($sformatf("r%0d", idx), dbg_data, exp);
    endtask

    // One full F/D/E/WB pass; retire and illegal_op must be low until after WB.
    task automatic run_instr(input logic exp_ret, input logic exp_ill);
        for (int p = 0; p < 3; p++) begin
            step(2'(p));
            chk($sformatf("retire_ph%0d", p), retire, 0);
            chk($sformatf("illegal_ph%0d", p), illegal_op, 0);
        end
        step(2'b11);
        chk("retire_wb", retire, exp_ret);
        chk("illegal_wb", illegal_op, exp_ill);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;

        // 1: reset state and LDI/LDI/ADD
        imem[0] = 16'h1405;
        imem[1] = 16'h1803;
        imem[2] = 16'h2600;
        do_reset();
        chk("rst_pc", pc, 0);
        chk("rst_zero", zero, 0);
        chk("rst_carry", carry, 0);
        chk("rst_retire", retire, 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_halted", halted, 0);
        chk("rst_seq_err", seq_err, 0);
        for (int r = 0; r < 4; r++) chk_reg(r, 8'h00);
        run_instr(1, 0);
        chk("t1_pc1", pc, 8'h01);
        run_instr(1, 0);
        run_instr(1, 0);
        chk_reg(1, 8'h08);
        chk_reg(2, 8'h03);
        chk("t1_zero", zero, 0);
        chk("t1_carry", carry, 0);
        chk("t1_pc", pc, 8'h03);

        // 2: SUB with borrow
        imem[3] = 16'h3900;
        run_instr(1, 0);
        chk_reg(2, 8'hFB);
        chk("t2_carry", carry, 1);
        chk("t2_zero", zero, 0);

        // 3: ADDI wraps to zero, BZ taken; then BZ not taken
        imem[4]  = 16'h1CFF;
        imem[5]  = 16'h8C01;
        imem[6]  = 16'hA010;
        imem[16] = 16'h8C01;
        imem[17] = 16'hA010;
        run_instr(1, 0);
        chk_reg(3, 8'hFF);
        run_instr(1, 0);
        chk_reg(3, 8'h00);
        chk("t3_zero", zero, 1);
        chk("t3_carry", carry, 1);
        run_instr(1, 0);
        chk("t3_bz_taken_pc", pc, 8'h10);
        run_instr(1, 0);
        chk_reg(3, 8'h01);
        chk("t3_zero2", zero, 0);
        chk("t3_carry2", carry, 0);
        run_instr(1, 0);
        chk("t3_bz_not_taken_pc", pc, 8'h12);

        // 4: illegal opcode behaves as NOP with an illegal_op pulse
        imem[0] = 16'hF123;
        do_reset();
        run_instr(1, 1);
        step(2'b00);
        chk("t4_illegal_clear", illegal_op, 0);
        chk("t4_retire_clear", retire, 0);
        for (int r = 0; r < 4; r++) chk_reg(r, 8'h00);
        chk("t4_pc", pc, 8'h01);
        step(2'b01);
        step(2'b10);
        step(2'b11);
        chk("t4_nop_pc", pc, 8'h02);

        // 5: HALT at pc=05 freezes the machine until reset
        for (int i = 1; i < 5; i++) imem[i] = 16'h0000;
        imem[5] = 16'hB000;
        for (int i = 0; i < 3; i++) run_instr(1, 0);
        chk("t5_pc_pre", pc, 8'h05);
        run_instr(1, 0);
        chk("t5_halted", halted, 1);
        chk("t5_pc_halt", pc, 8'h05);
        for (int k = 0; k < 2; k++) begin
            run_instr(0, 0);
            chk("t5_pc_hold", pc, 8'h05);
            chk("t5_halted_hold", halted, 1);
        end
        do_reset();
        chk("t5_halted_rst", halted, 0);
        chk("t5_pc_rst", pc, 8'h00);

        // 6: phase skip sets sticky seq_err
        do_reset();
        step(2'b00);
        chk("t6_seq_ok", seq_err, 0);
        step(2'b10);
        chk("t6_seq_err", seq_err, 1);
        step(2'b11);
        step(2'b00);
        step(2'b01);
        chk("t6_seq_sticky", seq_err, 1);

        // 6b: reset during E of ADD discards the instruction
        imem[0] = 16'h2600;
        do_reset();
        chk("t6_seq_rst", seq_err, 0);
        step(2'b00);
        step(2'b01);
        reset = 1'b1;
        step(2'b10);
        reset = 1'b0;
        chk("t6_pc_after_rst", pc, 8'h00);
        chk("t6_retire_after_rst", retire, 0);
        for (int r = 0; r < 4; r++) chk_reg(r, 8'h00);
        run_instr(1, 0);
        chk("t6_pc_first_retire", pc, 8'h01);
        chk("t6_seq_clean", seq_err, 0);
        for (int r = 0; r < 4; r++) chk_reg(r, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
